// File: rtl/dostring_pkg.sv
// Shared definitions for the dostring SPI LED-stream receiver: frame type codes,
// frame geometry, string FSM states and the frame classifier.
package dostring_pkg;

  localparam int         FRAME_BITS = 32;
  localparam logic [2:0] LED_HDR    = 3'b111;

  // Codes match the string transmitter.
  typedef enum logic [1:0] {
    TYPE_START = 2'd0,
    TYPE_LED   = 2'd1,
    TYPE_END   = 2'd2,
    TYPE_BAD   = 2'd3
  } frame_type_e;

  typedef enum logic {
    S_WAIT_START = 1'b0,
    S_IN_STRING  = 1'b1
  } str_state_e;

  typedef struct packed {
    logic [4:0] brightness;
    logic [7:0] blue;
    logic [7:0] green;
    logic [7:0] red;
  } led_fields_t;

  // All-ones is checked before the LED header, so a saturated LED frame reads as END.
  function automatic frame_type_e classify(input logic [FRAME_BITS-1:0] f);
    if (f == '0)                                 return TYPE_START;
    else if (f == '1)                            return TYPE_END;
    else if (f[FRAME_BITS-1 -: 3] == LED_HDR)    return TYPE_LED;
    else                                         return TYPE_BAD;
  endfunction

endpackage

// File: rtl/dostring_spi_rx_if.sv
// Bus bundle for the SPI LED-stream receiver: snooped SPI pins, error clear,
// and the decoded-frame / string-status outputs.
interface dostring_spi_rx_if;
  logic       mosi_in;
  logic       sck_in;
  logic       clear_errors;
  logic       rx_valid;
  logic [1:0] rx_type;
  logic [4:0] rx_brightness;
  logic [7:0] rx_blue;
  logic [7:0] rx_green;
  logic [7:0] rx_red;
  logic [7:0] rx_led_index;
  logic       string_done;
  logic [7:0] string_led_count;
  logic       err_sync;
  logic       err_header;
  logic       err_length;
  logic       err_orphan;

  modport master (
    output mosi_in, sck_in, clear_errors,
    input  rx_valid, rx_type, rx_brightness, rx_blue, rx_green, rx_red,
           rx_led_index, string_done, string_led_count,
           err_sync, err_header, err_length, err_orphan
  );

  modport slave (
    input  mosi_in, sck_in, clear_errors,
    output rx_valid, rx_type, rx_brightness, rx_blue, rx_green, rx_red,
           rx_led_index, string_done, string_led_count,
           err_sync, err_header, err_length, err_orphan
  );
endinterface

// File: rtl/spi_bit_capture.sv
// Synchronises the snooped mosi/sck pair, shifts bits in MSB first on sck rising
// edges and emits whole 32-bit frames; a stalled partial frame is dropped on timeout.
module spi_bit_capture
  import dostring_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 4096,
  parameter int TO_W         = 13
) (
  input  logic                  dostring_clk,
  input  logic                  dostring_reset,
  input  logic                  mosi_in,
  input  logic                  sck_in,
  output logic [FRAME_BITS-1:0] frame,
  output logic                  frame_strobe,
  output logic                  timeout_strobe
);

  logic [1:0]            mosi_sync;
  logic [1:0]            sck_sync;
  logic                  sck_d;
  logic                  sck_rise;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] shreg_nxt;
  logic [4:0]            bit_cnt;
  logic [TO_W-1:0]       to_cnt;

  assign sck_rise  = sck_sync[1] & ~sck_d;
  assign shreg_nxt = {shreg[FRAME_BITS-2:0], mosi_sync[1]};

  always_ff @(posedge dostring_clk or posedge dostring_reset) begin
    if (dostring_reset) begin
      mosi_sync <= '0;
      sck_sync  <= '0;
      sck_d     <= 1'b0;
    end else begin
      mosi_sync <= {mosi_sync[0], mosi_in};
      sck_sync  <= {sck_sync[0], sck_in};
      sck_d     <= sck_sync[1];
    end
  end

  // bit_cnt wraps 31->0 naturally, which re-arms capture for the next frame.
  always_ff @(posedge dostring_clk or posedge dostring_reset) begin
    if (dostring_reset) begin
      shreg          <= '0;
      bit_cnt        <= '0;
      to_cnt         <= '0;
      frame          <= '0;
      frame_strobe   <= 1'b0;
      timeout_strobe <= 1'b0;
    end else begin
      frame_strobe   <= 1'b0;
      timeout_strobe <= 1'b0;
      if (sck_rise) begin
        shreg   <= shreg_nxt;
        bit_cnt <= bit_cnt + 5'd1;
        to_cnt  <= '0;
        if (bit_cnt == 5'd31) begin
          frame        <= shreg_nxt;
          frame_strobe <= 1'b1;
        end
      end else if (bit_cnt == 5'd0) begin
        to_cnt <= '0;
      end else if (to_cnt == TO_W'(IDLE_TIMEOUT)) begin
        bit_cnt        <= '0;
        shreg          <= '0;
        to_cnt         <= '0;
        timeout_strobe <= 1'b1;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dostring_spi_rx.sv
// SPI LED-stream receiver: decodes captured frames, tracks string structure
// (start, N LEDs, end) and keeps sticky error flags.
module dostring_spi_rx
  import dostring_pkg::*;
#(
  parameter int EXPECTED_LEDS = 46,
  parameter int IDLE_TIMEOUT  = 4096,
  parameter int TO_W          = 13
) (
  input logic              dostring_clk,
  input logic              dostring_reset,
  dostring_spi_rx_if.slave bus
);

  logic [FRAME_BITS-1:0] frame;
  logic                  frame_strobe;
  logic                  timeout_strobe;
  frame_type_e           ftype;
  led_fields_t           fields;

  str_state_e            state, state_nxt;
  logic [7:0]            index, index_nxt;
  logic [7:0]            led_idx;
  logic                  ev_orphan, ev_header, ev_length, ev_done;

  spi_bit_capture #(
    .IDLE_TIMEOUT (IDLE_TIMEOUT),
    .TO_W         (TO_W)
  ) u_cap (
    .dostring_clk   (dostring_clk),
    .dostring_reset (dostring_reset),
    .mosi_in        (bus.mosi_in),
    .sck_in         (bus.sck_in),
    .frame          (frame),
    .frame_strobe   (frame_strobe),
    .timeout_strobe (timeout_strobe)
  );

  assign ftype  = classify(frame);
  assign fields = frame[28:0];

  always_ff @(posedge dostring_clk or posedge dostring_reset) begin
    if (dostring_reset) begin
      state <= S_WAIT_START;
      index <= '0;
    end else begin
      state <= state_nxt;
      index <= index_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (frame_strobe) begin
      case (state)
        S_WAIT_START: if (ftype == TYPE_START) state_nxt = S_IN_STRING;
        S_IN_STRING:  if (ftype == TYPE_END)   state_nxt = S_WAIT_START;
        default:      state_nxt = S_WAIT_START;
      endcase
    end
  end

  // Orphan LEDs report index 0 and leave the running index untouched.
  always_comb begin
    index_nxt = index;
    led_idx   = '0;
    ev_orphan = 1'b0;
    ev_header = 1'b0;
    ev_length = 1'b0;
    ev_done   = 1'b0;
    if (frame_strobe) begin
      case (state)
        S_WAIT_START: begin
          case (ftype)
            TYPE_START: index_nxt = '0;
            TYPE_LED:   ev_orphan = 1'b1;
            TYPE_BAD:   ev_header = 1'b1;
            default:    ;
          endcase
        end
        S_IN_STRING: begin
          case (ftype)
            TYPE_LED: begin
              led_idx   = index;
              index_nxt = (index == 8'hFF) ? index : index + 8'd1;
            end
            TYPE_START: begin
              ev_length = (index != 8'd0);
              index_nxt = '0;
            end
            TYPE_END: begin
              ev_done   = 1'b1;
              ev_length = (index != 8'(EXPECTED_LEDS));
            end
            default:  ev_header = 1'b1;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge dostring_clk or posedge dostring_reset) begin
    if (dostring_reset) begin
      bus.rx_valid         <= 1'b0;
      bus.rx_type          <= '0;
      bus.rx_brightness    <= '0;
      bus.rx_blue          <= '0;
      bus.rx_green         <= '0;
      bus.rx_red           <= '0;
      bus.rx_led_index     <= '0;
      bus.string_done      <= 1'b0;
      bus.string_led_count <= '0;
      bus.err_sync         <= 1'b0;
      bus.err_header       <= 1'b0;
      bus.err_length       <= 1'b0;
      bus.err_orphan       <= 1'b0;
    end else begin
      bus.rx_valid    <= frame_strobe;
      bus.string_done <= ev_done;
      if (frame_strobe) begin
        bus.rx_type       <= ftype;
        bus.rx_brightness <= fields.brightness;
        bus.rx_blue       <= fields.blue;
        bus.rx_green      <= fields.green;
        bus.rx_red        <= fields.red;
        bus.rx_led_index  <= led_idx;
      end
      if (ev_done) bus.string_led_count <= index;
      // A set event in the same cycle as clear_errors wins.
      bus.err_sync   <= timeout_strobe | (bus.err_sync   & ~bus.clear_errors);
      bus.err_header <= ev_header      | (bus.err_header & ~bus.clear_errors);
      bus.err_length <= ev_length      | (bus.err_length & ~bus.clear_errors);
      bus.err_orphan <= ev_orphan      | (bus.err_orphan & ~bus.clear_errors);
    end
  end

endmodule

// File: tb/tb_dostring_spi_rx.sv
// Directed bench for dostring_spi_rx: bit-bangs SPI frames and checks decoded
// frames, string status and sticky errors against hand-computed values.
module tb_dostring_spi_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dostring_spi_rx_if bus ();

  dostring_spi_rx #(
    .EXPECTED_LEDS (46),
    .IDLE_TIMEOUT  (4096),
    .TO_W          (13)
  ) dut (
    .dostring_clk   (clk),
    .dostring_reset (rst),
    .bus            (bus)
  );

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] F_START = 32'h0000_0000;
  localparam logic [31:0] F_END   = 32'hFFFF_FFFF;
  localparam logic [31:0] F_LED   = 32'hFF80_0280;  // 111, br=1F, B=80 G=02 R=80
  localparam logic [31:0] F_BAD   = 32'hBF80_0280;  // header 101

  typedef struct packed {
    logic [1:0] t;
    logic [4:0] br;
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] idx;
    logic       done;
  } rec_t;

  rec_t q[$];

  logic [52:0] all_outs;
  assign all_outs = {bus.rx_valid, bus.rx_type, bus.rx_brightness, bus.rx_blue,
                     bus.rx_green, bus.rx_red, bus.rx_led_index, bus.string_done,
                     bus.string_led_count, bus.err_sync, bus.err_header,
                     bus.err_length, bus.err_orphan};

  always @(negedge clk)
    if (bus.rx_valid)
      q.push_back({bus.rx_type, bus.rx_brightness, bus.rx_blue, bus.rx_green,
                   bus.rx_red, bus.rx_led_index, bus.string_done});

  task automatic send_bit(input logic b);
    @(negedge clk);
    bus.mosi_in = b;
    repeat (2) @(negedge clk);
    bus.sck_in = 1'b1;
    repeat (3) @(negedge clk);
    bus.sck_in = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] f);
    for (int i = 31; i >= 0; i--) send_bit(f[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.sck_in = 1'b0;
    bus.mosi_in = 1'b0;
    bus.clear_errors = 1'b0;
    idle(4);
    rst = 1'b0;
    idle(2);
    q.delete();
  endtask

  task automatic run_string(input int n);
    send_frame(F_START);
    for (int i = 0; i < n; i++) send_frame(F_LED);
    send_frame(F_END);
    idle(10);
  endtask

  task automatic test_reset();
    bus.sck_in = 1'b0;
    bus.mosi_in = 1'b0;
    bus.clear_errors = 1'b0;
    rst = 1'b1;
    idle(3);
    checks++;
    if (all_outs !== 53'd0) begin
      failures++;
      $display("FAIL reset_outs: got %0h expected 0", all_outs);
    end
    rst = 1'b0;
    idle(3);
    checks++;
    if (all_outs !== 53'd0) begin
      failures++;
      $display("FAIL post_reset_outs: got %0h expected 0", all_outs);
    end
  endtask

  task automatic test_latency();
    int lat;
    do_reset();
    for (int i = 0; i < 31; i++) send_bit(1'b0);
    @(negedge clk);
    bus.mosi_in = 1'b0;
    repeat (2) @(negedge clk);
    bus.sck_in = 1'b1;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 3) bus.sck_in = 1'b0;
      if (bus.rx_valid === 1'b1 && lat == 0) lat = k;
    end
    checks++;
    if (lat != 4) begin
      failures++;
      $display("FAIL latency: got %0d expected 4", lat);
    end
    checks++;
    if (q.size() != 1 || q[0].t !== 2'd0) begin
      failures++;
      $display("FAIL latency_type: got n=%0d expected one START", q.size());
    end
  endtask

  task automatic test_full_string();
    do_reset();
    run_string(46);
    checks++;
    if (q.size() != 48) begin
      failures++;
      $display("FAIL full_count: got %0d expected 48", q.size());
    end else begin
      checks++;
      if (q[0].t !== 2'd0 || q[0].done !== 1'b0) begin
        failures++;
        $display("FAIL full_start: got %0h expected type 0", q[0]);
      end
      for (int i = 0; i < 46; i++) begin
        checks++;
        if (q[i+1] !== {2'd1, 5'h1F, 8'h80, 8'h02, 8'h80, 8'(i), 1'b0}) begin
          failures++;
          $display("FAIL full_led%0d: got %0h expected idx %0d B80 G02 R80", i, q[i+1], i);
        end
      end
      checks++;
      if (q[47].t !== 2'd2 || q[47].done !== 1'b1) begin
        failures++;
        $display("FAIL full_end: got t=%0d done=%0b expected t=2 done=1", q[47].t, q[47].done);
      end
    end
    checks++;
    if (bus.string_led_count !== 8'd46) begin
      failures++;
      $display("FAIL full_led_count: got %0d expected 46", bus.string_led_count);
    end
    checks++;
    if ({bus.err_sync, bus.err_header, bus.err_length, bus.err_orphan} !== 4'b0) begin
      failures++;
      $display("FAIL full_errs: got %b expected 0000",
               {bus.err_sync, bus.err_header, bus.err_length, bus.err_orphan});
    end
  endtask

  task automatic test_short_string();
    q.delete();
    run_string(45);
    checks++;
    if (q.size() != 47 || q[46].done !== 1'b1) begin
      failures++;
      $display("FAIL short_done: got n=%0d expected 47 with done", q.size());
    end
    checks++;
    if (bus.string_led_count !== 8'd45) begin
      failures++;
      $display("FAIL short_led_count: got %0d expected 45", bus.string_led_count);
    end
    checks++;
    if (bus.err_length !== 1'b1) begin
      failures++;
      $display("FAIL short_err_length: got %b expected 1", bus.err_length);
    end
    @(negedge clk);
    bus.clear_errors = 1'b1;
    @(negedge clk);
    bus.clear_errors = 1'b0;
    idle(1);
    checks++;
    if (bus.err_length !== 1'b0) begin
      failures++;
      $display("FAIL short_clear: got %b expected 0", bus.err_length);
    end
  endtask

  task automatic test_timeout();
    q.delete();
    for (int i = 0; i < 17; i++) send_bit(1'b1);
    idle(4200);
    checks++;
    if (bus.err_sync !== 1'b1) begin
      failures++;
      $display("FAIL timeout_err_sync: got %b expected 1", bus.err_sync);
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL timeout_no_valid: got %0d pulses expected 0", q.size());
    end
    send_frame(F_START);
    idle(10);
    checks++;
    if (q.size() != 1 || q[0].t !== 2'd0) begin
      failures++;
      $display("FAIL timeout_resync: got n=%0d expected one START", q.size());
    end
    checks++;
    if (bus.err_header !== 1'b0) begin
      failures++;
      $display("FAIL timeout_header: got %b expected 0", bus.err_header);
    end
  endtask

  task automatic test_bad_header();
    q.delete();
    send_frame(F_LED);
    send_frame(F_BAD);
    send_frame(F_LED);
    idle(10);
    checks++;
    if (q.size() != 3) begin
      failures++;
      $display("FAIL bad_count: got %0d expected 3", q.size());
    end else begin
      checks++;
      if (q[1].t !== 2'd3) begin
        failures++;
        $display("FAIL bad_type: got %0d expected 3", q[1].t);
      end
      checks++;
      if (q[0].idx !== 8'd0 || q[2].t !== 2'd1 || q[2].idx !== 8'd1) begin
        failures++;
        $display("FAIL bad_next_idx: got %0d expected 1", q[2].idx);
      end
    end
    checks++;
    if (bus.err_header !== 1'b1) begin
      failures++;
      $display("FAIL bad_err_header: got %b expected 1", bus.err_header);
    end
    send_frame(F_END);
    idle(10);
  endtask

  task automatic test_orphan();
    do_reset();
    send_frame(F_LED);
    idle(10);
    checks++;
    if (q.size() != 1 || q[0].t !== 2'd1 || q[0].idx !== 8'd0) begin
      failures++;
      $display("FAIL orphan_frame: got n=%0d expected one LED idx 0", q.size());
    end
    checks++;
    if (bus.err_orphan !== 1'b1) begin
      failures++;
      $display("FAIL orphan_err: got %b expected 1", bus.err_orphan);
    end
    send_frame(F_END);
    idle(10);
    checks++;
    if (q.size() != 2 || q[1].t !== 2'd2 || q[1].done !== 1'b0) begin
      failures++;
      $display("FAIL orphan_end: got n=%0d expected END without string_done", q.size());
    end
    checks++;
    if (bus.err_length !== 1'b0) begin
      failures++;
      $display("FAIL orphan_err_length: got %b expected 0", bus.err_length);
    end
  endtask

  task automatic test_reset_midframe();
    for (int i = 31; i > 11; i--) send_bit(F_LED[i]);
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    checks++;
    if (all_outs !== 53'd0) begin
      failures++;
      $display("FAIL midreset_outs: got %0h expected 0", all_outs);
    end
    rst = 1'b0;
    idle(2);
    q.delete();
    run_string(1);
    checks++;
    if (q.size() != 3 || q[1].t !== 2'd1 || q[1].idx !== 8'd0 || q[2].done !== 1'b1) begin
      failures++;
      $display("FAIL midreset_frames: got n=%0d expected START LED0 END", q.size());
    end
    checks++;
    if (bus.string_led_count !== 8'd1) begin
      failures++;
      $display("FAIL midreset_led_count: got %0d expected 1", bus.string_led_count);
    end
    checks++;
    if (bus.err_length !== 1'b1) begin
      failures++;
      $display("FAIL midreset_err_length: got %b expected 1", bus.err_length);
    end
    checks++;
    if ({bus.err_sync, bus.err_header, bus.err_orphan} !== 3'b0) begin
      failures++;
      $display("FAIL midreset_other_errs: got %b expected 000",
               {bus.err_sync, bus.err_header, bus.err_orphan});
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_full_string();
    test_short_string();
    test_timeout();
    test_bad_header();
    test_orphan();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dostring_spi_rx.md
Name: dostring_spi_rx

Overview:
- SPI LED-stream receiver and decoder. Snoops the mosi/sck pair that drives the wand and rebuilds each 32-bit frame: start, LED or end.
- Reports decoded colours, brightness and LED index. Checks string structure: start, N LED frames, end.
- Used as the loopback monitor on the board and as the checker in the string-generator testbench.

Parameters:
- EXPECTED_LEDS, 46, number of LED frames required between a start frame and an end frame.
- IDLE_TIMEOUT, 4096, dostring_clk cycles with no sck rising edge before a partial frame is discarded.
- TO_W, 13, width of the timeout counter; must satisfy 2^TO_W > IDLE_TIMEOUT.

Ports:
- dostring_clk  in  1  system clock, 100 MHz
- dostring_reset  in  1  reset
- mosi_in  in  1  serial data, asynchronous to dostring_clk
- sck_in  in  1  serial clock, asynchronous, idle low
- clear_errors  in  1  one-cycle pulse; clears the sticky error flags
- rx_valid  out  1  one-cycle pulse; a frame has been decoded
- rx_type  out  2  0=START, 1=LED, 2=END, 3=BAD
- rx_brightness  out  5  frame bits [28:24]
- rx_blue  out  8  frame bits [23:16]
- rx_green  out  8  frame bits [15:8]
- rx_red  out  8  frame bits [7:0]
- rx_led_index  out  8  0-based index of an LED frame within the current string
- string_done  out  1  one-cycle pulse on a valid end frame
- string_led_count  out  8  number of LED frames in the last completed string
- err_sync  out  1  sticky; a timeout discarded a partial frame
- err_header  out  1  sticky; an LED-class frame had a bad header
- err_length  out  1  sticky; string_led_count != EXPECTED_LEDS, or a string was truncated by a start frame
- err_orphan  out  1  sticky; an LED frame arrived outside a string

Behaviour:
- Reset is dostring_reset, asynchronous, active-high; clock is dostring_clk. All outputs and all state are 0 in reset; FSM is in S_WAIT_START.
- Input capture:
  - mosi_in and sck_in each pass through a 2-flop synchroniser.
  - An sck rising edge is detected as sync_sck & ~sck_d.
  - On each detected edge, sync_mosi shifts into a 32-bit register, MSB first, and the 5-bit bit_cnt increments.
- Latency: rx_valid pulses exactly 4 clocks after the 32nd sck rising edge at the pin (2 sync + 1 edge + 1 decode register). The rx_* fields are stable from that pulse until the next rx_valid.
- Timing assumption: sck high and low phases are each >= 3 dostring_clk cycles.
- Frame classification (frame = 32 captured bits), in priority order:
  - All zeros -> START.
  - All ones -> END (an all-ones LED frame is therefore always END).
  - Bits [31:29] == 3'b111 -> LED.
  - Otherwise -> BAD; set err_header.
- Timeout:
  - The timeout counter resets on every sck edge and counts up while bit_cnt != 0.
  - On reaching IDLE_TIMEOUT: clear bit_cnt and the shift register, set err_sync, no rx_valid.
  - The counter is held at 0 while bit_cnt == 0.
- String FSM, S_WAIT_START:
  - START -> S_IN_STRING with index <= 0.
  - LED -> err_orphan; rx_valid still pulses with rx_led_index = 0; index unchanged.
  - END and BAD -> no state change; END does not pulse string_done.
- String FSM, S_IN_STRING:
  - LED -> rx_led_index = index, then index <= index + 1. Index saturates at 255, no wrap.
  - START with index > 0 -> err_length, index <= 0, stay in S_IN_STRING.
  - START with index == 0 -> stay in S_IN_STRING, no error.
  - END -> string_led_count <= index, string_done pulse on the same cycle as rx_valid, err_length if index != EXPECTED_LEDS, go to S_WAIT_START.
  - BAD -> err_header, stay in S_IN_STRING, index unchanged.
- Sticky errors:
  - Set by events; cleared by clear_errors.
  - If a set event and clear_errors occur in the same cycle, set wins.
- Reset mid-frame drops the partial frame with no error. The first frame after reset is decoded from bit 0 only if reset released while sck was idle.

Decomposition:
- Shared package dostring_pkg:
  - frame type codes (TYPE_START/LED/END/BAD, matching the codes used by the transmitter);
  - FRAME_BITS=32 and LED_HDR=3'b111;
  - FSM state constants.
- Sub-module spi_bit_capture: synchronisers, edge detect, shift register, bit counter and timeout. It outputs a 32-bit frame plus a frame_strobe and a timeout_strobe. Classification and the string FSM stay in the top module.

Test Plan:
- Start frame, 46 LED frames {111,5'h1F,B=80,G=02,R=80}, then 32 ones -> 48 rx_valid pulses; LEDs show index 0..45 with B=0x80/G=0x02/R=0x80; string_done with string_led_count=46; all error flags 0.
- Same stimulus with 45 LED frames -> string_done with string_led_count=45; err_length=1; a following clear_errors pulse -> err_length=0.
- 17 sck bits, then idle for 4096 clocks, then a full start frame -> err_sync=1; next rx_valid has rx_type=START and no header error.
- LED frame with header 3'b101 inside a string -> rx_type=BAD, err_header=1, next LED frame keeps the index it would otherwise have had.
- LED frame before any start frame -> rx_valid with rx_type=LED, rx_led_index=0, err_orphan=1; string_done is not asserted by the following end frame.
- Assert reset after 20 bits of an LED frame, release, send start+LED+end -> all outputs 0 during reset; then string_done with string_led_count=1 and err_length=1 (EXPECTED_LEDS=46).
